mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch path and the load/store path of the core.
- Accepts one transaction at a time and sequences the memory enable, address and write strobe.
- Returns read data or a write acknowledge to the owning requester.
- Data accesses have priority; a starvation counter guarantees fetch progress.
- Instruction fetch can flush an in-flight fetch when the PC is redirected on a taken branch or jump.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
MEM_LATENCY, 2, cycles from mem_en to valid mem_rdata (legal range >= 1)
STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending (>= 1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_WIDTH  fetch address
if_flush  in  1  discard response of in-flight fetch
if_gnt  out  1  fetch accepted, one-cycle pulse
if_rvalid  out  1  fetch data valid, one-cycle pulse
if_rdata  out  DATA_WIDTH  fetched instruction
d_req  in  1  load/store request, held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_WIDTH  load/store address
d_wdata  in  DATA_WIDTH  store data
d_gnt  out  1  load/store accepted, one-cycle pulse
d_rvalid  out  1  load data valid or store acknowledge, one-cycle pulse
d_rdata  out  DATA_WIDTH  load data, 0 for stores
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- All outputs are registered. On rst, every output is 0, state is IDLE, the starvation counter is 0, and the flush flag is cleared.
- States:
  - IDLE: no transaction.
  - ISSUE: one cycle; mem_en, gnt and the latched address/data are driven.
  - WAIT: latency counter runs for MEM_LATENCY cycles.
  - RESP: one cycle; rvalid is driven.
- Arbitration happens in IDLE and RESP, so back-to-back transactions are possible. Throughput is one access per MEM_LATENCY+2 cycles.
- Arbitration rule:
  - Data wins if d_req=1, unless starve_cnt == STARVE_LIMIT and if_req=1; in that case fetch wins.
  - starve_cnt increments on each data grant while if_req=1.
  - starve_cnt clears on a fetch grant, or when if_req=0 at arbitration.
  - starve_cnt saturates at STARVE_LIMIT.
- Timing, with a request sampled in cycle T:
  - T+1 (ISSUE): gnt=1, mem_en=1, mem_we=d_we (data owner only), mem_addr/mem_wdata hold the latched values.
  - The memory presents mem_rdata in cycle T+1+MEM_LATENCY; the arbiter samples it at the end of that cycle.
  - T+2+MEM_LATENCY (RESP): rvalid=1 and rdata registered for the owner.
- Outside ISSUE, mem_en, mem_we, mem_addr and mem_wdata are 0.
- rdata outputs hold their last value outside RESP. A store writes 0 to d_rdata in RESP.
- Requester inputs are sampled only at arbitration; changes after gnt are ignored.
- if_flush asserted in any cycle of a fetch's ISSUE or WAIT state sets a flush flag.
  - In RESP, if_rvalid is suppressed and if_rdata is not updated.
  - The flag clears on leaving RESP.
  - if_flush in IDLE, or while data owns the port, has no effect.
- A request without a grant is not cancelled by flush; the requester deasserts it.
- Simultaneous RESP and a new request: the response pulse and the next arbitration decision occur in the same cycle; the new ISSUE follows in the next cycle.
- Reset mid-transaction returns to IDLE at once. The in-flight transaction produces no rvalid and its gnt is not repeated.

Test Plan:
- Fetch only, MEM_LATENCY=2: if_req=1 with if_addr=0x10 in cycle 0 -> cycle 1: if_gnt=1, mem_en=1, mem_addr=0x10; mem_rdata=0xDEADBEEF in cycle 3 -> cycle 4: if_rvalid=1, if_rdata=0xDEADBEEF; busy=1 in cycles 1-4.
- Contention: if_req and d_req (load, d_addr=0x200) both high in cycle 0 -> d_gnt in cycle 1, d_rvalid in cycle 4; fetch chosen in cycle 4, so if_gnt=1 in cycle 5.
- Starvation, STARVE_LIMIT=4: d_req and if_req held high continuously -> grant order is D,D,D,D,IF,D; starve_cnt returns to 0 after the IF grant.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x55 -> cycle 1: mem_we=1, mem_wdata=0x55 for exactly one cycle; cycle 4: d_rvalid=1, d_rdata=0.
- Flush: fetch issued in cycle 1, if_flush=1 in cycle 2 -> no if_rvalid in cycle 4 and if_rdata unchanged; a new if_req in cycle 4 gets if_gnt in cycle 5 and completes normally.
- Reset: rst=1 in cycle 2 of a load -> all outputs 0 immediately; no d_rvalid; after release, a new request is granted one cycle after it is sampled.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// Data wins by default; a saturating starvation counter forces a fetch grant after a data streak.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_flush_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam int unsigned LatW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LatW-1:0] LatLoad   = LatW'(MEM_LATENCY - 1);
  localparam logic [StvW-1:0] StarveMax = StvW'(STARVE_LIMIT);

  logic [1:0]            state_q, state_d;
  logic [LatW-1:0]       lat_q, lat_d;
  logic [StvW-1:0]       starve_q, starve_d;
  logic                  own_d_q, own_d_d;
  logic                  we_q, we_d;
  logic                  flush_q, flush_d;
  logic                  if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic                  if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic                  mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;

  logic arb, pick_data, pick_if, last_wait;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    own_d_d     = own_d_q;
    we_d        = we_q;
    flush_d     = flush_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    arb       = (state_q == StIdle) || (state_q == StResp);
    pick_data = d_req_i && !((starve_q == StarveMax) && if_req_i);
    pick_if   = if_req_i && !pick_data;
    last_wait = (state_q == StWait) && (lat_q == '0);

    case (state_q)
      StIssue: begin
        state_d = StWait;
        lat_d   = LatLoad;
      end
      StWait: begin
        if (lat_q == '0) state_d = StResp;
        else             lat_d   = lat_q - 1'b1;
      end
      StResp: begin
        state_d = StIdle;
        flush_d = 1'b0;
      end
      default: ;
    endcase

    if (!own_d_q && if_flush_i && ((state_q == StIssue) || (state_q == StWait))) begin
      flush_d = 1'b1;
    end

    // A flush seen in the final wait cycle must still suppress the response.
    if (last_wait) begin
      if (own_d_q) begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = we_q ? '0 : mem_rdata_i;
      end else if (!flush_q && !if_flush_i) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = mem_rdata_i;
      end
    end

    if (arb) begin
      if (pick_data || pick_if) begin
        state_d     = StIssue;
        own_d_d     = pick_data;
        we_d        = pick_data && d_we_i;
        if_gnt_d    = pick_if;
        d_gnt_d     = pick_data;
        mem_en_d    = 1'b1;
        mem_we_d    = pick_data && d_we_i;
        mem_addr_d  = pick_data ? d_addr_i : if_addr_i;
        mem_wdata_d = pick_data ? d_wdata_i : '0;
        flush_d     = 1'b0;
      end
      if (!if_req_i || pick_if) begin
        starve_d = '0;
      end else if (pick_data && (starve_q != StarveMax)) begin
        starve_d = starve_q + 1'b1;
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      lat_q       <= '0;
      starve_q    <= '0;
      own_d_q     <= 1'b0;
      we_q        <= 1'b0;
      flush_q     <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      own_d_q     <= own_d_d;
      we_q        <= we_d;
      flush_q     <= flush_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt_o    = if_gnt_q;
  assign d_gnt_o     = d_gnt_q;
  assign if_rvalid_o = if_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;

endmodule
